// File: rtl/vga_pkg.sv
// Shared definitions for the pixel scan-out block: logical frame size,
// 640x480@60 timing constants, frame-store depth, clear-FSM states and
// the frame-store address helper.
package vga_pkg;

  localparam int unsigned H_RES    = 160;
  localparam int unsigned V_RES    = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned SCALE    = 4;
  localparam int unsigned SCALE_SH = $clog2(SCALE);

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_TOTAL  = 525;

  localparam int unsigned FB_DEPTH = H_RES * V_RES;
  localparam int unsigned ADDR_W   = 15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // row*160 + col built from shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] row,
                                                input logic [7:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 7) + (r << 5) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster timing from a 50 MHz clock.
//   clk, resetn    : system clock, async active-low reset
//   pix_en         : toggles every clk; counters advance when it is high
//   h_cnt, v_cnt   : raster position (0..799, 0..524)
//   hs_raw, vs_raw : active-low syncs for the current counter value
//   active         : current position is inside the visible 640x480 area
//   vblank_start   : 1-clk pulse at h_cnt==0, v_cnt==480 on a pix_en cycle
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       active,
  output logic       vblank_start
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          if (v_cnt == V_LAST) v_cnt <= '0;
          else                 v_cnt <= v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  always_comb begin
    hs_raw       = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_raw       = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    vblank_start = pix_en && (h_cnt == '0) && (v_cnt == V_ACT);
  end

endmodule

// File: rtl/pixel_scanout.sv
// Pixel-plot receiver and VGA scan-out.
// Plot writes (x, y, colour) land in a 160x120x3 frame store, which is
// scanned out as 640x480@60 with 4x4 replication. A clear request sweeps
// the store to zero one address per clk while scan-out continues.
//   clk, resetn       : system clock, async active-low reset
//   x, y, colour, plot: plot write port (one write per clk while plot=1)
//   clear             : start a clear sweep (ignored while one is running)
//   busy              : clear sweep in progress
//   wr_drop           : 1-clk pulse, the previous clk's plot was ignored
//   vblank_start      : 1-clk pulse at the start of vertical blank
//   VGA_*             : DAC pins, 2 clks behind the raster counters
module pixel_scanout
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  input  logic       clear,
  output logic       busy,
  output logic       wr_drop,
  output logic       vblank_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] VGA_R,
  output logic [9:0] VGA_G,
  output logic [9:0] VGA_B
);

  localparam logic [7:0]        X_LIM     = 8'(H_RES);
  localparam logic [7:0]        Y_LIM     = 8'(V_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       active;

  vga_timing u_timing (
    .clk          (clk),
    .resetn       (resetn),
    .pix_en       (pix_en),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .hs_raw       (hs_raw),
    .vs_raw       (vs_raw),
    .active       (active),
    .vblank_start (vblank_start)
  );

  // Frame store: simple dual-port, registered read, not reset
  logic [COLOUR_W-1:0] mem [FB_DEPTH];
  logic [COLOUR_W-1:0] rd_data;
  logic [COLOUR_W-1:0] wr_data;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   plot_addr;
  logic                wr_en;

  // Outside the visible area the read is parked at 0 to stay in range
  always_comb begin
    rd_addr = '0;
    if (active) rd_addr = fb_addr(8'(v_cnt >> SCALE_SH), 8'(h_cnt >> SCALE_SH));
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  // Clear FSM and plot arbitration
  clr_state_t        state;
  clr_state_t        state_nxt;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_nxt;
  logic              wr_drop_nxt;
  logic              plot_in_range;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      wr_drop  <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      wr_drop  <= wr_drop_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    clr_addr_nxt  = clr_addr;
    wr_drop_nxt   = 1'b0;
    wr_en         = 1'b0;
    plot_addr     = fb_addr(y, x);
    wr_addr       = plot_addr;
    wr_data       = colour;
    plot_in_range = (x < X_LIM) && (y < Y_LIM);
    busy          = (state == ST_CLEAR);
    case (state)
      ST_IDLE: begin
        if (clear) begin
          // a plot arriving with the clear request loses
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
          wr_drop_nxt  = plot;
        end else if (plot) begin
          if (plot_in_range) wr_en       = 1'b1;
          else               wr_drop_nxt = 1'b1;
        end
      end
      ST_CLEAR: begin
        wr_en       = 1'b1;
        wr_addr     = clr_addr;
        wr_data     = '0;
        wr_drop_nxt = plot;
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = ST_IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + 1'b1;
        end
      end
    endcase
  end

  // Syncs and blank ride alongside the store read (stage 1), then all
  // pins are registered together (stage 2).
  logic hs_d;
  logic vs_d;
  logic act_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      act_d       <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      hs_d        <= hs_raw;
      vs_d        <= vs_raw;
      act_d       <= active;
      VGA_HS      <= hs_d;
      VGA_VS      <= vs_d;
      VGA_BLANK_N <= act_d;
      VGA_R       <= {10{rd_data[2] & act_d}};
      VGA_G       <= {10{rd_data[1] & act_d}};
      VGA_B       <= {10{rd_data[0] & act_d}};
    end
  end

  always_comb begin
    VGA_CLK    = pix_en;
    VGA_SYNC_N = 1'b0;
  end

endmodule
